// File: rtl/clk_timer_pkg.sv
// Shared types and helpers for the multi-channel interval timer.
// Counter limits and a saturating increment used by every channel.
package clk_timer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } ch_state_e;

    localparam int CNT_W_MIN  = 4;
    localparam int CNT_W_MAX  = 32;
    localparam int NUM_CH_MAX = 16;

    // All-ones value for a counter of width w, computed wide so w == 32 works.
    function automatic logic [31:0] cnt_lim(input int w);
        cnt_lim = 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        sat_inc = (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/clk_interval_timer_if.sv
// Control strobes and result bus of the interval timer.
// master drives start/stop/clear, slave is the timer itself.
interface clk_interval_timer_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic                      clear;
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH-1:0]         stop;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH*CNT_W-1:0]   result;
    logic [NUM_CH-1:0]         result_valid;
    logic [NUM_CH-1:0]         ovf;
    logic [NUM_CH*CNT_W-1:0]   max_result;

    modport master (
        output clear, start, stop,
        input  busy, result, result_valid, ovf, max_result
    );

    modport slave (
        input  clear, start, stop,
        output busy, result, result_valid, ovf, max_result
    );
endinterface

// File: rtl/clk_timer_channel.sv
// One timer channel: edge detect, IDLE/COUNT FSM, saturating counter,
// last-result and running-maximum registers.
module clk_timer_channel
    import clk_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] max_result
);

    localparam logic [31:0]      LIM     = cnt_lim(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIM);

    ch_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             start_q;
    logic             stop_q;
    logic             start_rise;
    logic             stop_rise;
    logic [CNT_W-1:0] cnt_next;

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop & ~stop_q;
    assign cnt_next   = CNT_W'(sat_inc(32'(cnt), LIM));

    // Saturation is sticky in the counter value itself: once it hits CNT_MAX
    // it stays there, so "saturated" is simply cnt_next == CNT_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
            max_result   <= '0;
        end else begin
            // Edge history keeps tracking through clear so release is glitch-free.
            start_q <= start;
            stop_q  <= stop;
            if (clear) begin
                state        <= ST_IDLE;
                cnt          <= '0;
                busy         <= 1'b0;
                result       <= '0;
                result_valid <= 1'b0;
                ovf          <= 1'b0;
                max_result   <= '0;
            end else begin
                result_valid <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (start_rise) begin
                            state <= ST_COUNT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_COUNT: begin
                        if (stop_rise) begin
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            result       <= cnt_next;
                            ovf          <= (cnt_next == CNT_MAX);
                            result_valid <= 1'b1;
                            if (cnt_next > max_result)
                                max_result <= cnt_next;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/clk_interval_timer.sv
// Multi-channel interval timer: NUM_CH independent channels packed onto
// the shared result buses, channel i at bits [i*CNT_W +: CNT_W].
module clk_interval_timer
    import clk_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    clk_interval_timer_if.slave tif
);

    logic [NUM_CH-1:0][CNT_W-1:0] res_a;
    logic [NUM_CH-1:0][CNT_W-1:0] max_a;
    logic [NUM_CH-1:0]            busy_a;
    logic [NUM_CH-1:0]            vld_a;
    logic [NUM_CH-1:0]            ovf_a;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .clear        (tif.clear),
            .start        (tif.start[i]),
            .stop         (tif.stop[i]),
            .busy         (busy_a[i]),
            .result       (res_a[i]),
            .result_valid (vld_a[i]),
            .ovf          (ovf_a[i]),
            .max_result   (max_a[i])
        );
    end

    assign tif.busy         = busy_a;
    assign tif.result       = res_a;
    assign tif.result_valid = vld_a;
    assign tif.ovf          = ovf_a;
    assign tif.max_result   = max_a;

endmodule

// File: tb/tb_clk_interval_timer.sv
// Bench for clk_interval_timer: an 8-bit and a 4-bit instance share stimulus;
// a timestamp-based model is compared every cycle, plus literal checkpoints.
module tb_clk_interval_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] st = 2'b00;
    logic [1:0] sp = 2'b00;

    always #5 clk = ~clk;

    clk_interval_timer_if #(.NUM_CH(2), .CNT_W(8)) if8 ();
    clk_interval_timer_if #(.NUM_CH(2), .CNT_W(4)) if4 ();

    assign if8.clear = clr;
    assign if8.start = st;
    assign if8.stop  = sp;
    assign if4.clear = clr;
    assign if4.start = st;
    assign if4.stop  = sp;

    clk_interval_timer #(.NUM_CH(2), .CNT_W(8)) dut8 (.clk(clk), .reset_n(reset_n), .tif(if8));
    clk_interval_timer #(.NUM_CH(2), .CNT_W(4)) dut4 (.clk(clk), .reset_n(reset_n), .tif(if4));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Accessors: d = 0 selects the 8-bit instance, d = 1 the 4-bit one.
    function automatic logic [31:0] a_res(int d, int c);
        return (d == 0) ? 32'(if8.result[c*8 +: 8]) : 32'(if4.result[c*4 +: 4]);
    endfunction
    function automatic logic [31:0] a_max(int d, int c);
        return (d == 0) ? 32'(if8.max_result[c*8 +: 8]) : 32'(if4.max_result[c*4 +: 4]);
    endfunction
    function automatic logic a_busy(int d, int c);
        return (d == 0) ? if8.busy[c] : if4.busy[c];
    endfunction
    function automatic logic a_vld(int d, int c);
        return (d == 0) ? if8.result_valid[c] : if4.result_valid[c];
    endfunction
    function automatic logic a_ovf(int d, int c);
        return (d == 0) ? if8.ovf[c] : if4.ovf[c];
    endfunction

    // Model: remember the cycle number of the accepted start edge, and on the
    // stop edge report min(now - start_cycle, limit).
    int lim [2] = '{255, 15};
    int cyc;
    int m_busy [2][2];
    int m_n    [2][2];
    int m_res  [2][2];
    int m_vld  [2][2];
    int m_ovf  [2][2];
    int m_max  [2][2];
    int m_ps   [2][2];
    int m_pp   [2][2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_busy[d][c] = 0; m_n[d][c] = 0; m_res[d][c] = 0; m_vld[d][c] = 0;
                m_ovf[d][c] = 0; m_max[d][c] = 0; m_ps[d][c] = 0; m_pp[d][c] = 0;
            end
    endtask

    task automatic model_step();
        int rs, rp, dd;
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                rs = (st[c] && m_ps[d][c] == 0) ? 1 : 0;
                rp = (sp[c] && m_pp[d][c] == 0) ? 1 : 0;
                m_ps[d][c] = st[c] ? 1 : 0;
                m_pp[d][c] = sp[c] ? 1 : 0;
                if (clr) begin
                    m_busy[d][c] = 0; m_res[d][c] = 0; m_vld[d][c] = 0;
                    m_ovf[d][c] = 0; m_max[d][c] = 0;
                end else begin
                    m_vld[d][c] = 0;
                    if (m_busy[d][c] == 0) begin
                        if (rs != 0) begin
                            m_busy[d][c] = 1;
                            m_n[d][c] = cyc;
                        end
                    end else if (rp != 0) begin
                        dd = cyc - m_n[d][c];
                        m_res[d][c] = (dd > lim[d]) ? lim[d] : dd;
                        m_ovf[d][c] = (dd >= lim[d]) ? 1 : 0;
                        m_vld[d][c] = 1;
                        if (m_res[d][c] > m_max[d][c]) m_max[d][c] = m_res[d][c];
                        m_busy[d][c] = 0;
                    end
                end
            end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
            @(negedge clk);
            if (!reset_n) model_reset();
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("cyc%0d d%0d ch%0d busy", cyc, d, c), 64'(a_busy(d, c)), 64'(m_busy[d][c]));
                    chk($sformatf("cyc%0d d%0d ch%0d result", cyc, d, c), 64'(a_res(d, c)), 64'(m_res[d][c]));
                    chk($sformatf("cyc%0d d%0d ch%0d valid", cyc, d, c), 64'(a_vld(d, c)), 64'(m_vld[d][c]));
                    chk($sformatf("cyc%0d d%0d ch%0d ovf", cyc, d, c), 64'(a_ovf(d, c)), 64'(m_ovf[d][c]));
                    chk($sformatf("cyc%0d d%0d ch%0d max", cyc, d, c), 64'(a_max(d, c)), 64'(m_max[d][c]));
                end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        cyc_n(1);
        clr = 1'b0;
        cyc_n(1);
    endtask

    initial begin
        // Reset held with inputs toggling
        repeat (5) begin
            st = ~st; sp = ~sp; clr = ~clr;
            cyc_n(1);
            chk("rst busy", 64'(if8.busy), 64'd0);
            chk("rst valid", 64'(if8.result_valid), 64'd0);
            chk("rst result", 64'(if8.result), 64'd0);
        end
        st = '0; sp = '0; clr = 1'b0;
        cyc_n(1);
        reset_n = 1'b1;
        cyc_n(3);

        // Basic: 11-cycle interval on ch0
        st[0] = 1'b1;
        cyc_n(1);
        chk("basic busy at N", 64'(a_busy(0, 0)), 64'd1);
        st[0] = 1'b0;
        cyc_n(10);
        chk("basic busy at N+10", 64'(a_busy(0, 0)), 64'd1);
        sp[0] = 1'b1;
        cyc_n(1);
        chk("basic result", 64'(a_res(0, 0)), 64'd11);
        chk("basic valid", 64'(a_vld(0, 0)), 64'd1);
        chk("basic ovf", 64'(a_ovf(0, 0)), 64'd0);
        chk("basic busy at M", 64'(a_busy(0, 0)), 64'd0);
        sp[0] = 1'b0;
        cyc_n(1);
        chk("basic valid drop", 64'(a_vld(0, 0)), 64'd0);

        // Overlapping channels
        pulse_clear();
        for (int k = 0; k <= 31; k++) begin
            st = {1'(k == 2), 1'(k == 0)};
            sp = {1'(k == 30), 1'(k == 7)};
            cyc_n(1);
            if (k == 7) begin
                chk("ovl ch0 result", 64'(a_res(0, 0)), 64'd7);
                chk("ovl ch0 valid", 64'(a_vld(0, 0)), 64'd1);
                chk("ovl ch1 no valid", 64'(a_vld(0, 1)), 64'd0);
            end
            if (k == 30) begin
                chk("ovl ch1 result", 64'(a_res(0, 1)), 64'd28);
                chk("ovl ch1 valid", 64'(a_vld(0, 1)), 64'd1);
            end
        end
        chk("ovl ch0 max", 64'(a_max(0, 0)), 64'd7);
        chk("ovl ch1 max", 64'(a_max(0, 1)), 64'd28);
        chk("ovl w4 ch1 sat", 64'(a_res(1, 1)), 64'd15);

        // Saturation on the 4-bit instance
        pulse_clear();
        for (int k = 0; k <= 46; k++) begin
            st = {1'b0, 1'(k == 0 || k == 40)};
            sp = {1'b0, 1'(k == 30 || k == 45)};
            cyc_n(1);
            if (k == 30) begin
                chk("sat w4 result", 64'(a_res(1, 0)), 64'd15);
                chk("sat w4 ovf", 64'(a_ovf(1, 0)), 64'd1);
                chk("sat w8 result", 64'(a_res(0, 0)), 64'd30);
            end
            if (k == 45) begin
                chk("sat2 w4 result", 64'(a_res(1, 0)), 64'd5);
                chk("sat2 w4 ovf", 64'(a_ovf(1, 0)), 64'd0);
                chk("sat2 w4 max", 64'(a_max(1, 0)), 64'd15);
                chk("sat2 w8 max", 64'(a_max(0, 0)), 64'd30);
            end
        end

        // Start+stop together, extra start ignored, stop in IDLE
        pulse_clear();
        for (int k = 0; k <= 13; k++) begin
            st = {1'b0, 1'(k == 5 || k == 7)};
            sp = {1'b0, 1'(k == 5 || k == 9 || k == 12)};
            cyc_n(1);
            if (k == 5) chk("edge busy after both", 64'(a_busy(0, 0)), 64'd1);
            if (k == 9) begin
                chk("edge result", 64'(a_res(0, 0)), 64'd4);
                chk("edge valid", 64'(a_vld(0, 0)), 64'd1);
            end
            if (k == 12) begin
                chk("idle stop no valid", 64'(a_vld(0, 0)), 64'd0);
                chk("idle stop holds result", 64'(a_res(0, 0)), 64'd4);
            end
        end

        // Abort by clear
        for (int k = 0; k <= 19; k++) begin
            st = {1'b0, 1'(k == 10)};
            sp = {1'b0, 1'(k == 18)};
            clr = 1'(k == 14);
            cyc_n(1);
            if (k == 18) begin
                chk("abort no valid", 64'(a_vld(0, 0)), 64'd0);
                chk("abort result", 64'(a_res(0, 0)), 64'd0);
                chk("abort busy", 64'(a_busy(0, 0)), 64'd0);
                chk("abort max", 64'(a_max(0, 0)), 64'd0);
            end
        end
        st = '0; sp = '0; clr = 1'b0;

        // Reset mid-measurement
        st[0] = 1'b1;
        cyc_n(1);
        st[0] = 1'b0;
        chk("mid busy", 64'(a_busy(0, 0)), 64'd1);
        cyc_n(2);
        reset_n = 1'b0;
        #1;
        chk("async rst busy", 64'(a_busy(0, 0)), 64'd0);
        chk("async rst result", 64'(if8.result), 64'd0);
        cyc_n(3);
        reset_n = 1'b1;
        cyc_n(2);
        sp[0] = 1'b1;
        cyc_n(1);
        chk("post rst no valid", 64'(a_vld(0, 0)), 64'd0);
        chk("post rst result", 64'(a_res(0, 0)), 64'd0);
        sp[0] = 1'b0;
        cyc_n(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
